conv_stim_gen: RTL

Synthesizable, parametrised stimulus generator for the parallel-to-serial converter in the PHY datapath. It produces bursts of parallel words for BIST and loopback testing, replacing fixed-sequence bench drivers. Each burst has programmable length, data pattern, and PCLK width mode. It drives the converter's ENB, PCLK and parallel data inputs directly, with ENB framing the burst.

---
 rtl/conv_stim_gen_if.sv | 42 ++++
 rtl/conv_stim_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conv_stim_gen_if.sv
// ---------------------------------------------------------------------------
// conv_stim_gen_if
// Bus between the burst stimulus generator and its controller/converter.
//   start      : burst request
//   mode       : pattern select (counter, LFSR, alternating, constant)
//   width_sel  : requested converter width mode
//   num_words  : words in the burst
//   pclk       : latched width mode presented to the converter
//   enb        : converter enable, framing the burst
//   data       : parallel word, bits above the active width are zero
//   valid      : one-cycle pulse for each new data word
//   busy       : burst in progress
//   done       : one-cycle pulse at burst end
//   word_cnt   : words issued in the current or last burst
// The generator uses the master modport; the controller side uses slave.
// ---------------------------------------------------------------------------
interface conv_stim_gen_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [1:0]        width_sel;
  logic [CNT_W-1:0]  num_words;
  logic [1:0]        pclk;
  logic              enb;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    input  start, mode, width_sel, num_words,
    output pclk, enb, data, valid, busy, done, word_cnt
  );

  modport slave (
    output start, mode, width_sel, num_words,
    input  pclk, enb, data, valid, busy, done, word_cnt
  );
endinterface

// File: rtl/conv_stim_gen.sv
// ---------------------------------------------------------------------------
// conv_stim_gen
// Burst stimulus generator for the parallel-to-serial converter. A burst is
// a lead-in with enb high, num_words words each held HOLD_CYCLES clocks,
// then a tail with enb still high, finishing with a done pulse.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; aborts any burst without done
//   bus    : conv_stim_gen_if master modport (control in, converter out)
// ---------------------------------------------------------------------------
module conv_stim_gen #(
  parameter int          DATA_W      = 32,
  parameter int          CNT_W       = 8,
  parameter int          HOLD_CYCLES = 4,
  parameter int          LEAD_CYCLES = 4,
  parameter int          TAIL_CYCLES = 8,
  parameter logic [31:0] SEED        = 32'h0F00FF55,
  parameter logic [31:0] LFSR_TAPS   = 32'hA3000000
) (
  input logic              clk,
  input logic              reset,
  conv_stim_gen_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LEAD, RUN, TAIL} state_t;

  localparam logic [DATA_W-1:0] SEED_T    = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] TAPS_T    = DATA_W'(LFSR_TAPS);
  localparam logic [DATA_W-1:0] ALL_ONES  = '1;
  localparam logic [DATA_W-1:0] MASK_HALF = ALL_ONES >> (DATA_W / 2);
  localparam logic [DATA_W-1:0] MASK_QTR  = ALL_ONES >> (DATA_W - DATA_W / 4);

  // The shared phase timer is loaded with (cycles - 1), so it only needs
  // to hold the largest phase length minus one.
  localparam int MAXC  = (LEAD_CYCLES > HOLD_CYCLES) ?
                         ((LEAD_CYCLES > TAIL_CYCLES) ? LEAD_CYCLES : TAIL_CYCLES) :
                         ((HOLD_CYCLES > TAIL_CYCLES) ? HOLD_CYCLES : TAIL_CYCLES);
  localparam int TMR_W = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [TMR_W-1:0] LEAD_LD = TMR_W'(LEAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TAIL_LD = TMR_W'(TAIL_CYCLES - 1);

  state_t            state_q, state_n;
  logic [TMR_W-1:0]  tmr_q, tmr_n;
  logic [DATA_W-1:0] pat_q, pat_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [1:0]        mode_q, mode_n;
  logic [1:0]        pclk_q, pclk_n;
  logic [CNT_W-1:0]  num_q, num_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              enb_q, enb_n;
  logic              valid_q, valid_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  // LFSR mode cannot start from zero or it would lock up.
  function automatic logic [DATA_W-1:0] first_pattern(input logic [1:0] m);
    if (m == 2'b01 && SEED_T == '0) return DATA_W'(1);
    return SEED_T;
  endfunction

  function automatic logic [DATA_W-1:0] next_pattern(input logic [DATA_W-1:0] p,
                                                     input logic [1:0]        m);
    case (m)
      2'b00:   return p + DATA_W'(1);
      2'b01:   return (p >> 1) ^ (p[0] ? TAPS_T : '0);
      2'b10:   return ~p;
      default: return p;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] w);
    case (w)
      2'b01:   return MASK_HALF;
      2'b10:   return MASK_QTR;
      default: return ALL_ONES;
    endcase
  endfunction

  // State and output registers; reset clears everything, including any
  // burst in flight, without raising done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      mode_q  <= 2'b00;
      pclk_q  <= 2'b00;
      num_q   <= '0;
      cnt_q   <= '0;
      enb_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tmr_q   <= tmr_n;
      pat_q   <= pat_n;
      data_q  <= data_n;
      mode_q  <= mode_n;
      pclk_q  <= pclk_n;
      num_q   <= num_n;
      cnt_q   <= cnt_n;
      enb_q   <= enb_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-output logic; valid and done are pulses and fall
  // back to zero unless a branch raises them.
  always_comb begin
    state_n = state_q;
    tmr_n   = tmr_q;
    pat_n   = pat_q;
    data_n  = data_q;
    mode_n  = mode_q;
    pclk_n  = pclk_q;
    num_n   = num_q;
    cnt_n   = cnt_q;
    enb_n   = enb_q;
    busy_n  = busy_q;
    valid_n = 1'b0;
    done_n  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_words != '0) begin
            mode_n  = bus.mode;
            pclk_n  = (bus.width_sel == 2'b11) ? 2'b00 : bus.width_sel;
            num_n   = bus.num_words;
            cnt_n   = '0;
            enb_n   = 1'b1;
            busy_n  = 1'b1;
            tmr_n   = LEAD_LD;
            state_n = LEAD;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      LEAD: begin
        if (tmr_q == '0) begin
          pat_n   = first_pattern(mode_q);
          data_n  = pat_n & width_mask(pclk_q);
          valid_n = 1'b1;
          cnt_n   = CNT_W'(1);
          tmr_n   = HOLD_LD;
          state_n = RUN;
        end else begin
          tmr_n = tmr_q - TMR_W'(1);
        end
      end

      RUN: begin
        if (tmr_q != '0) begin
          tmr_n = tmr_q - TMR_W'(1);
        end else if (cnt_q == num_q) begin
          tmr_n   = TAIL_LD;
          state_n = TAIL;
        end else begin
          pat_n   = next_pattern(pat_q, mode_q);
          data_n  = pat_n & width_mask(pclk_q);
          valid_n = 1'b1;
          cnt_n   = cnt_q + CNT_W'(1);
          tmr_n   = HOLD_LD;
        end
      end

      TAIL: begin
        if (tmr_q == '0) begin
          enb_n   = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tmr_n = tmr_q - TMR_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.pclk     = pclk_q;
  assign bus.enb      = enb_q;
  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.word_cnt = cnt_q;

endmodule
